// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between the RV32 execute stage and a single-ported word-wide data memory.
// Optional build macro LSU_MISALIGN_SPLIT_EN splits misaligned H/HU/W accesses into two word accesses.
module lsu_mem_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] regData,
  output logic        resp_valid,
  output logic [31:0] Load_data,
  output logic        access_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] MEM_wr_data,
  input  logic        mem_ack,
  input  logic [31:0] MEM_rd_data
);

  // state  | meaning
  // IDLE   | ready for a new request
  // ISSUE  | first (or only) memory access in flight
  // RESP   | one-cycle response, resp_valid high
  // ISSUE2 | second word of a split misaligned access
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic [1:0] ISSUE2 = 2'd3;
`endif

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] load_data_q, load_data_d;
  logic        err_q, err_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        is_load_q, is_load_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] lo_word_q, lo_word_d;
`endif

  logic        is_load, is_store, is_mem, accept;
  logic        illegal, misaligned, err_accept;
  logic [3:0]  base_be;
  logic [7:0]  be8;
  logic [31:0] repl, wdata;
  logic [4:0]  wsh, rsh;
  logic [31:0] shifted, load_ext;

  assign is_load  = (OPCODE == 7'b0000011);
  assign is_store = (OPCODE == 7'b0100011);
  assign is_mem   = is_load | is_store;
  assign accept   = (state_q == IDLE) & req_valid & is_mem;

  assign illegal    = (func3[1:0] == 2'b11) | (func3[2] & func3[1]) | (is_store & func3[2]);
  assign misaligned = ((func3[1:0] == 2'b01) & addr[0]) |
                      ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

  always_comb begin
    base_be = 4'b0001;
    repl    = {4{regData[7:0]}};
    case (func3[1:0])
      2'b01: begin
        base_be = 4'b0011;
        repl    = {2{regData[15:0]}};
      end
      2'b10: begin
        base_be = 4'b1111;
        repl    = regData;
      end
      default: ;
    endcase
  end

  // Byte i of the store value lands on lane (offset + i) mod 4, so rotate the replicated value.
  assign be8   = {4'b0000, base_be} << addr[1:0];
  assign wsh   = {addr[1:0], 3'b000};
  assign wdata = (repl << wsh) | (repl >> (6'd32 - {1'b0, wsh}));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign err_accept = illegal;
`else
  assign err_accept = illegal | misaligned | (|be8[7:4]);
`endif

  assign rsh = {off_q, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] merge_lo, merge_hi;
  assign merge_lo = (state_q == ISSUE2) ? lo_word_q : MEM_rd_data;
  assign merge_hi = (state_q == ISSUE2) ? MEM_rd_data : 32'd0;
  assign shifted  = (merge_lo >> rsh) | (merge_hi << (6'd32 - {1'b0, rsh}));
`else
  assign shifted  = MEM_rd_data >> rsh;
`endif

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    wr_data_d   = wr_data_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    timer_d     = timer_q;
    off_d       = off_q;
    f3_d        = f3_q;
    is_load_d   = is_load_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    be_hi_d     = be_hi_q;
    lo_word_d   = lo_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (err_accept) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d    = ISSUE;
            err_d      = 1'b0;
            mem_addr_d = {addr[31:2], 2'b00};
            mem_be_d   = be8[3:0];
            mem_we_d   = is_store;
            wr_data_d  = wdata;
            off_d      = addr[1:0];
            f3_d       = func3;
            is_load_d  = is_load;
            timer_d    = TMO_LOAD;
`ifdef LSU_MISALIGN_SPLIT_EN
            be_hi_d    = be8[7:4];
`endif
          end
        end
      end
      ISSUE: begin
        if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (|be_hi_q) begin
            state_d    = ISSUE2;
            lo_word_d  = MEM_rd_data;
            mem_addr_d = mem_addr_q + 32'd4;
            mem_be_d   = be_hi_q;
            timer_d    = TMO_LOAD;
          end else begin
`endif
            state_d  = RESP;
            mem_be_d = 4'b0000;
            mem_we_d = 1'b0;
            if (is_load_q) load_data_d = load_ext;
`ifdef LSU_MISALIGN_SPLIT_EN
          end
`endif
        end else if (timer_q == 16'd0) begin
          state_d  = RESP;
          err_d    = 1'b1;
          mem_be_d = 4'b0000;
          mem_we_d = 1'b0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ISSUE2: begin
        if (mem_ack) begin
          state_d  = RESP;
          mem_be_d = 4'b0000;
          mem_we_d = 1'b0;
          if (is_load_q) load_data_d = load_ext;
        end else if (timer_q == 16'd0) begin
          state_d  = RESP;
          err_d    = 1'b1;
          mem_be_d = 4'b0000;
          mem_we_d = 1'b0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      wr_data_q   <= 32'd0;
      load_data_q <= 32'd0;
      err_q       <= 1'b0;
      timer_q     <= 16'd0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      is_load_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      be_hi_q     <= 4'd0;
      lo_word_q   <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      wr_data_q   <= wr_data_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      is_load_q   <= is_load_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      be_hi_q     <= be_hi_d;
      lo_word_q   <= lo_word_d;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign access_err  = resp_valid & err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  assign mem_req     = (state_q == ISSUE) | (state_q == ISSUE2);
`else
  assign mem_req     = (state_q == ISSUE);
`endif
  // Stall covers the accept cycle itself, so it is partly combinational on req_valid.
  assign stall       = ~reset & ((state_q != IDLE) | accept);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign MEM_wr_data = wr_data_q;
  assign Load_data   = load_data_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: loads, stores, errors, wait states, timeout, reset abort.
module tb_lsu_mem_sequencer;

  logic        clk, reset, req_valid, req_ready;
  logic [6:0]  OPCODE;
  logic [2:0]  func3;
  logic [31:0] addr, regData;
  logic        resp_valid, access_err, stall;
  logic [31:0] Load_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, MEM_wr_data, MEM_rd_data;
  logic [3:0]  mem_be;

  int passed = 0;
  int total  = 0;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  lsu_mem_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .OPCODE(OPCODE), .func3(func3), .addr(addr), .regData(regData),
    .resp_valid(resp_valid), .Load_data(Load_data), .access_err(access_err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .MEM_wr_data(MEM_wr_data), .mem_ack(mem_ack), .MEM_rd_data(MEM_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at the current negedge, hold it over one accept edge, then withdraw it.
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    OPCODE = op; func3 = f3; addr = a; regData = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready, mem_req, mem_we, resp_valid, access_err, stall} !== 6'b100000)
      $display("FAIL reset_ctrl: got %b want 100000",
               {req_ready, mem_req, mem_we, resp_valid, access_err, stall});
    else passed++;
    total++;
    if ({mem_be, mem_addr, MEM_wr_data, Load_data} !== 100'd0)
      $display("FAIL reset_data: be=%b addr=%h wd=%h ld=%h want all zero",
               mem_be, mem_addr, MEM_wr_data, Load_data);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lb;
    mem_ack = 1'b1; MEM_rd_data = 32'h80FF_1234;
    OPCODE = OP_LD; func3 = 3'b000; addr = 32'h103; regData = 32'd0; req_valid = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL lb_stall_accept: got %b want 1", stall);
    else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1000, 32'h100})
      $display("FAIL lb_issue: req=%b we=%b be=%b addr=%h want 1 0 1000 00000100",
               mem_req, mem_we, mem_be, mem_addr);
    else passed++;
    @(negedge clk);
    total++;
    if ({resp_valid, access_err, mem_req, stall} !== 4'b1001)
      $display("FAIL lb_resp_flags: got %b want 1001", {resp_valid, access_err, mem_req, stall});
    else passed++;
    total++;
    if (Load_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", Load_data);
    else passed++;
    @(negedge clk);
    total++;
    if ({resp_valid, stall, req_ready} !== 3'b001)
      $display("FAIL lb_after: got %b want 001", {resp_valid, stall, req_ready});
    else passed++;
    mem_ack = 1'b0;
  endtask

  task automatic test_sh;
    mem_ack = 1'b0;
    drive(OP_ST, 3'b001, 32'h202, 32'h0000_BEEF);
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr, MEM_wr_data} !==
        {1'b1, 1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF})
      $display("FAIL sh_issue: req=%b we=%b be=%b addr=%h wd=%h want 1 1 1100 00000200 beefbeef",
               mem_req, mem_we, mem_be, mem_addr, MEM_wr_data);
    else passed++;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if ({resp_valid, access_err, Load_data} !== {1'b1, 1'b0, 32'hFFFF_FF80})
      $display("FAIL sh_resp: rv=%b err=%b ld=%h want 1 0 ffffff80", resp_valid, access_err, Load_data);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_lw_wait;
    int held;
    bit stall_ok;
    mem_ack = 1'b0;
    drive(OP_LD, 3'b010, 32'h10, 32'd0);
    held = mem_req ? 1 : 0;
    stall_ok = stall;
    for (int i = 0; i < 20 && !resp_valid; i++) begin
      @(negedge clk);
      if (mem_req) held++;
      if (!stall) stall_ok = 1'b0;
      if (held == 6 && mem_req) begin
        mem_ack = 1'b1; MEM_rd_data = 32'h1234_5678;
      end
    end
    mem_ack = 1'b0;
    total++;
    if (held !== 6) $display("FAIL lw_req_hold: got %0d cycles want 6", held);
    else passed++;
    total++;
    if ({stall_ok, resp_valid, access_err} !== 3'b110)
      $display("FAIL lw_resp: stall_ok=%b rv=%b err=%b want 1 1 0", stall_ok, resp_valid, access_err);
    else passed++;
    total++;
    if (Load_data !== 32'h1234_5678) $display("FAIL lw_data: got %h want 12345678", Load_data);
    else passed++;
    @(negedge clk);
    total++;
    if (stall !== 1'b0) $display("FAIL lw_stall_end: got %b want 0", stall);
    else passed++;
  endtask

  task automatic test_misaligned;
`ifdef LSU_MISALIGN_SPLIT_EN
    mem_ack = 1'b0;
    drive(OP_LD, 3'b101, 32'h7, 32'd0);
    total++;
    if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b1000, 32'h4})
      $display("FAIL split_first: req=%b be=%b addr=%h want 1 1000 00000004", mem_req, mem_be, mem_addr);
    else passed++;
    mem_ack = 1'b1; MEM_rd_data = 32'hAA00_0000;
    @(negedge clk);
    MEM_rd_data = 32'h0000_0055;
    total++;
    if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b0001, 32'h8})
      $display("FAIL split_second: req=%b be=%b addr=%h want 1 0001 00000008", mem_req, mem_be, mem_addr);
    else passed++;
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if ({resp_valid, access_err, Load_data} !== {1'b1, 1'b0, 32'h0000_55AA})
      $display("FAIL split_resp: rv=%b err=%b ld=%h want 1 0 000055aa", resp_valid, access_err, Load_data);
    else passed++;
`else
    drive(OP_LD, 3'b101, 32'h7, 32'd0);
    total++;
    if ({resp_valid, access_err, mem_req, Load_data} !== {3'b110, 32'h1234_5678})
      $display("FAIL lhu_misaligned: rv=%b err=%b req=%b ld=%h want 1 1 0 12345678",
               resp_valid, access_err, mem_req, Load_data);
    else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_illegal_store;
    bit seen_req;
    drive(OP_ST, 3'b100, 32'h300, 32'hDEAD_BEEF);
    seen_req = mem_req;
    total++;
    if ({resp_valid, access_err} !== 2'b11)
      $display("FAIL sw_illegal_resp: got %b want 11", {resp_valid, access_err});
    else passed++;
    @(negedge clk);
    seen_req = seen_req | mem_req;
    total++;
    if ({seen_req, resp_valid, req_ready} !== 3'b001)
      $display("FAIL sw_illegal_after: req_seen=%b rv=%b ready=%b want 0 0 1", seen_req, resp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_ignored_opcode;
    OPCODE = 7'b0110011; func3 = 3'b000; addr = 32'h0; req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, stall, mem_req, resp_valid} !== 4'b1000)
      $display("FAIL ignored_op: got %b want 1000", {req_ready, stall, mem_req, resp_valid});
    else passed++;
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    mem_ack = 1'b1; MEM_rd_data = 32'h00C3_0000;
    OPCODE = OP_ST; func3 = 3'b000; addr = 32'h1; regData = 32'h0000_00A5; req_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_we, mem_be, mem_addr, MEM_wr_data} !== {1'b1, 4'b0010, 32'h0, 32'hA5A5_A5A5})
      $display("FAIL b2b_sb: we=%b be=%b addr=%h wd=%h want 1 0010 00000000 a5a5a5a5",
               mem_we, mem_be, mem_addr, MEM_wr_data);
    else passed++;
    OPCODE = OP_LD; func3 = 3'b100; addr = 32'h2;
    @(negedge clk);
    total++;
    if ({resp_valid, access_err, req_ready} !== 3'b100)
      $display("FAIL b2b_sb_resp: got %b want 100", {resp_valid, access_err, req_ready});
    else passed++;
    @(negedge clk);
    total++;
    if ({req_ready, stall} !== 2'b11)
      $display("FAIL b2b_reaccept: got %b want 11", {req_ready, stall});
    else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_be} !== {1'b1, 1'b0, 4'b0100})
      $display("FAIL b2b_lbu_issue: req=%b we=%b be=%b want 1 0 0100", mem_req, mem_we, mem_be);
    else passed++;
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if ({resp_valid, Load_data} !== {1'b1, 32'h0000_00C3})
      $display("FAIL b2b_lbu_data: rv=%b ld=%h want 1 000000c3", resp_valid, Load_data);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int held;
    mem_ack = 1'b0;
    drive(OP_LD, 3'b010, 32'h20, 32'd0);
    held = mem_req ? 1 : 0;
    for (int i = 0; i < 400 && !resp_valid; i++) begin
      @(negedge clk);
      if (mem_req) held++;
    end
    total++;
    if (held !== 255) $display("FAIL timeout_len: got %0d cycles want 255", held);
    else passed++;
    total++;
    if ({resp_valid, access_err, mem_req, Load_data} !== {3'b110, 32'h0000_00C3})
      $display("FAIL timeout_resp: rv=%b err=%b req=%b ld=%h want 1 1 0 000000c3",
               resp_valid, access_err, mem_req, Load_data);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int resp_seen;
    mem_ack = 1'b0;
    drive(OP_LD, 3'b010, 32'h40, 32'd0);
    total++;
    if (mem_req !== 1'b1) $display("FAIL rst_mid_pre: req=%b want 1", mem_req);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({mem_req, req_ready, stall, mem_addr, Load_data} !== {3'b010, 32'h0, 32'h0})
      $display("FAIL rst_mid_abort: req=%b ready=%b stall=%b addr=%h ld=%h want 0 1 0 0 0",
               mem_req, req_ready, stall, mem_addr, Load_data);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    total++;
    if (resp_seen !== 0) $display("FAIL rst_mid_noresp: got %0d responses want 0", resp_seen);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; OPCODE = 7'd0; func3 = 3'd0; addr = 32'd0;
    regData = 32'd0; mem_ack = 1'b0; MEM_rd_data = 32'd0;
    test_reset;
    test_lb;
    test_sh;
    test_lw_wait;
    test_misaligned;
    test_illegal_store;
    test_ignored_opcode;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
